// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types and default sizing constants.
package lc3b_types;

  localparam int unsigned LC3B_WIDTH   = 16;
  localparam int unsigned LC3B_NREGS   = 8;
  localparam int unsigned LC3B_AW      = $clog2(LC3B_NREGS);
  localparam int unsigned LC3B_MAXPEND = 3;
  localparam int unsigned LC3B_CW      = $clog2(LC3B_MAXPEND + 1);

  typedef logic [LC3B_AW-1:0] lc3b_reg;
  typedef logic [LC3B_CW-1:0] lc3b_sb_count;

endpackage

// File: rtl/sb_counter.sv
// Per-register scoreboard counter: tracks in-flight writes to one register.
// Increments on issue, decrements on writeback, holds when both or neither
// occur. Saturates at MAXPEND and at zero; a lone decrement at zero is flagged.
module sb_counter
  import lc3b_types::*;
#(
  parameter int unsigned MAXPEND = LC3B_MAXPEND,
  parameter int unsigned CW      = $clog2(MAXPEND + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_stall,
  output logic [CW-1:0] o_count,
  output logic          o_underflow
);

  logic [CW-1:0] r_count;

  // Underflow: a retire with nothing pending and no same-cycle issue.
  assign o_underflow = i_dec && !i_inc && !i_stall && (r_count == '0);
  assign o_count     = r_count;

  // Pending-write count update; frozen while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_stall) begin
      if (i_inc && !i_dec && (r_count != CW'(MAXPEND))) begin
        r_count <= r_count + 1'b1;
      end else if (i_dec && !i_inc && (r_count != '0)) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_sb_bypass.sv
// Decode-stage register file with NRD combinational read ports, one writeback
// port, write-to-read bypass, and a per-register scoreboard of in-flight writes
// that drives read-hazard and issue-ready indications.
module regfile_sb_bypass
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH   = LC3B_WIDTH,
  parameter int unsigned NREGS   = LC3B_NREGS,
  parameter int unsigned NRD     = 2,
  parameter int unsigned MAXPEND = LC3B_MAXPEND,
  localparam int unsigned AW     = $clog2(NREGS),
  localparam int unsigned CW     = $clog2(MAXPEND + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_hazard,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_dest,
  output logic                 issue_ready,
  input  logic                 wb_load,
  input  logic [AW-1:0]        wb_dest,
  input  logic [WIDTH-1:0]     wb_data,
  output logic                 sb_err
);

  localparam bit POW2 = (NREGS == (1 << AW));

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return POW2 ? 1'b1 : (int'(a) < int'(NREGS));
  endfunction

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_sb_err;

  logic             w_wb_eff;
  logic             w_wb_we;
  logic             w_iss_eff;
  logic             w_ovf;
  logic [NREGS-1:0] w_inc;
  logic [NREGS-1:0] w_dec;
  logic [NREGS-1:0] w_underflow;
  logic [CW-1:0]    w_count [NREGS];
  logic [CW-1:0]    w_eff   [NREGS];

  // rst_n also gates the writeback strobe so a held reset shows zero on every
  // read port even if the writeback bus is active.
  assign w_wb_eff  = wb_load && !stall && rst_n;
  assign w_wb_we   = w_wb_eff && addr_ok(wb_dest);
  assign w_iss_eff = issue_valid && issue_ready && !stall;
  assign w_ovf     = issue_valid && !issue_ready && !stall;

  // Readiness uses effective counts only, never the issue being decided.
  assign issue_ready = !addr_ok(issue_dest) || (w_eff[issue_dest] < CW'(MAXPEND));
  assign sb_err      = r_sb_err;

  // Architectural register array write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_we) begin
      r_regs[wb_dest] <= wb_data;
    end
  end

  // Sticky scoreboard error: underflow on any register or a blocked issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sb_err <= 1'b0;
    end else if (!stall && ((|w_underflow) || w_ovf)) begin
      r_sb_err <= 1'b1;
    end
  end

  for (genvar r = 0; r < NREGS; r++) begin : g_sb
    assign w_inc[r] = w_iss_eff && (issue_dest == AW'(r));
    assign w_dec[r] = w_wb_eff  && (wb_dest    == AW'(r));

    sb_counter #(
      .MAXPEND (MAXPEND),
      .CW      (CW)
    ) u_cnt (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_inc       (w_inc[r]),
      .i_dec       (w_dec[r]),
      .i_stall     (stall),
      .o_count     (w_count[r]),
      .o_underflow (w_underflow[r])
    );

    // A write retiring this cycle no longer counts as pending.
    assign w_eff[r] = (w_dec[r] && (w_count[r] != '0)) ? (w_count[r] - 1'b1) : w_count[r];
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]    w_addr;
    logic             w_ok;
    logic             w_byp;
    logic [WIDTH-1:0] w_data;

    assign w_addr = rd_addr[p*AW +: AW];
    assign w_ok   = addr_ok(w_addr);
    assign w_byp  = w_wb_eff && w_ok && (wb_dest == w_addr);
    assign w_data = !w_ok ? '0 : (w_byp ? wb_data : r_regs[w_addr]);

    assign rd_data[p*WIDTH +: WIDTH] = w_data;
    assign rd_hazard[p]              = w_ok && (w_eff[w_addr] != '0);
  end

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Scoreboard bench for regfile_sb_bypass: expectations are queued as stimulus
// is applied and compared against the DUT's combinational outputs.
module tb_regfile_sb_bypass;
  import lc3b_types::*;

  localparam int unsigned W  = 16;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst_n;
  logic          stall;
  logic [2*AW-1:0] rd_addr;
  logic [2*W-1:0]  rd_data;
  logic [1:0]    rd_hazard;
  logic          issue_valid;
  logic [AW-1:0] issue_dest;
  logic          issue_ready;
  logic          wb_load;
  logic [AW-1:0] wb_dest;
  logic [W-1:0]  wb_data;
  logic          sb_err;

  regfile_sb_bypass #(
    .WIDTH   (16),
    .NREGS   (8),
    .NRD     (2),
    .MAXPEND (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_hazard   (rd_hazard),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .issue_ready (issue_ready),
    .wb_load     (wb_load),
    .wb_dest     (wb_dest),
    .wb_data     (wb_data),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int unsigned {S_D0, S_D1, S_H0, S_H1, S_RDY, S_ERR} sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sbq[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [31:0] observed(input sel_e s);
    case (s)
      S_D0:    return {16'h0, rd_data[15:0]};
      S_D1:    return {16'h0, rd_data[31:16]};
      S_H0:    return {31'h0, rd_hazard[0]};
      S_H1:    return {31'h0, rd_hazard[1]};
      S_RDY:   return {31'h0, issue_ready};
      default: return {31'h0, sb_err};
    endcase
  endfunction

  task automatic expect_v(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    sbq.push_back(e);
  endtask

  // Let combinational outputs settle, then retire every queued expectation.
  task automatic sample();
    exp_t e;
    #2;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      check(e.tag, observed(e.sel), e.exp);
    end
  endtask

  task automatic drive(input logic s, input logic iv, input logic [AW-1:0] id,
                       input logic wl, input logic [AW-1:0] wd, input logic [W-1:0] wdat,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    stall       = s;
    issue_valid = iv;
    issue_dest  = id;
    wb_load     = wl;
    wb_dest     = wd;
    wb_data     = wdat;
    rd_addr     = {a1, a0};
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 1, 3, 16'h1234, 3, 3);
    expect_v("rst_d0", S_D0, 0);
    expect_v("rst_d1", S_D1, 0);
    expect_v("rst_h0", S_H0, 0);
    expect_v("rst_h1", S_H1, 0);
    expect_v("rst_rdy", S_RDY, 1);
    expect_v("rst_err", S_ERR, 0);
    sample();
    tick();
    tick();

    // Read R3 after reset
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 3, 3);
    expect_v("r3_d0", S_D0, 0);
    expect_v("r3_d1", S_D1, 0);
    expect_v("r3_h0", S_H0, 0);
    sample();
    tick();

    // Bypass on R5
    drive(0, 1, 5, 0, 0, 0, 5, 5);
    expect_v("iss5_rdy", S_RDY, 1);
    sample();
    tick();
    drive(0, 0, 0, 1, 5, 16'hBEEF, 5, 5);
    expect_v("byp_d0", S_D0, 32'hBEEF);
    expect_v("byp_d1", S_D1, 32'hBEEF);
    expect_v("byp_h0", S_H0, 0);
    expect_v("byp_h1", S_H1, 0);
    sample();
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 5);
    expect_v("arr_d0", S_D0, 32'hBEEF);
    expect_v("arr_err", S_ERR, 0);
    sample();

    // Double-pending R2
    drive(0, 1, 2, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 2, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 2, 2);
    expect_v("r2c2_h0", S_H0, 1);
    expect_v("r2c2_h1", S_H1, 1);
    sample();
    tick();
    drive(0, 0, 0, 1, 2, 16'h1111, 2, 2);
    expect_v("r2wb1_h0", S_H0, 1);
    expect_v("r2wb1_d0", S_D0, 32'h1111);
    sample();
    tick();
    drive(0, 0, 0, 1, 2, 16'h2222, 2, 2);
    expect_v("r2wb2_h0", S_H0, 0);
    expect_v("r2wb2_d0", S_D0, 32'h2222);
    sample();
    tick();
    drive(0, 0, 0, 0, 0, 0, 2, 2);
    expect_v("r2_d0", S_D0, 32'h2222);
    expect_v("r2_h0", S_H0, 0);
    sample();

    // Same-cycle issue and retire on R1
    drive(0, 1, 1, 0, 0, 0, 1, 1);
    tick();
    drive(0, 1, 1, 1, 1, 16'h0101, 1, 1);
    expect_v("r1ir_rdy", S_RDY, 1);
    sample();
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    expect_v("r1_h0", S_H0, 1);
    expect_v("r1_d0", S_D0, 32'h0101);
    sample();
    drive(0, 0, 0, 1, 1, 16'h0101, 1, 1);
    tick();

    // Saturate R4
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4, 0, 0, 0, 4, 4);
      tick();
    end
    drive(0, 1, 4, 0, 0, 0, 4, 4);
    expect_v("sat_rdy", S_RDY, 0);
    expect_v("sat_err0", S_ERR, 0);
    sample();
    tick();
    drive(0, 0, 4, 0, 0, 0, 4, 4);
    expect_v("ovf_err", S_ERR, 1);
    expect_v("ovf_h0", S_H0, 1);
    expect_v("ovf_rdy", S_RDY, 0);
    sample();
    tick();
    drive(0, 0, 4, 1, 4, 16'h4444, 4, 4);
    expect_v("wb4_rdy", S_RDY, 1);
    expect_v("wb4_h0", S_H0, 1);
    sample();
    tick();

    // Stall freeze on R6/R7
    drive(0, 1, 6, 0, 0, 0, 6, 7);
    tick();
    drive(1, 1, 7, 1, 6, 16'h00AA, 6, 7);
    expect_v("stl_d0", S_D0, 0);
    expect_v("stl_h0", S_H0, 1);
    expect_v("stl_h1", S_H1, 0);
    sample();
    tick();
    drive(0, 0, 0, 0, 0, 0, 6, 7);
    expect_v("pst_d0", S_D0, 0);
    expect_v("pst_h0", S_H0, 1);
    expect_v("pst_h1", S_H1, 0);
    sample();
    tick();
    drive(0, 0, 0, 1, 6, 16'h00AA, 6, 7);
    expect_v("wb6_d0", S_D0, 32'h00AA);
    expect_v("wb6_h0", S_H0, 0);
    sample();
    tick();
    drive(0, 0, 0, 0, 0, 0, 6, 6);
    expect_v("r6_d0", S_D0, 32'h00AA);
    expect_v("r6_d1", S_D1, 32'h00AA);
    expect_v("r6_h0", S_H0, 0);
    sample();

    // Reset mid-operation, then a stray writeback underflows
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 4, 6);
    expect_v("mrst_err", S_ERR, 0);
    expect_v("mrst_d1", S_D1, 0);
    expect_v("mrst_h0", S_H0, 0);
    expect_v("mrst_rdy", S_RDY, 1);
    sample();
    tick();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 4, 4);
    expect_v("prst_h0", S_H0, 0);
    expect_v("prst_d0", S_D0, 0);
    sample();
    drive(0, 0, 0, 1, 4, 16'h5555, 4, 4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 4);
    expect_v("unf_err", S_ERR, 1);
    expect_v("unf_d0", S_D0, 32'h5555);
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
